// File: rtl/clint_types_pkg.sv
// Shared definitions for the CLINT timer unit: register offsets, time type,
// register-select encoding and the byte-lane merge helper.
package clint_types_pkg;

  typedef logic [63:0] mtime_t;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_e;

  // Lanes with a cleared enable keep their old byte.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] result;
    result = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) result[8*i +: 8] = new_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/clint_timer_unit_if.sv
// Peripheral bus between a requester and the CLINT timer unit slave port.
interface clint_timer_unit_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic        ren;
  logic        wen;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output addr, wdata, byte_en, ren, wen,
                  input  rdata, ack, err);
  modport slave  (input  addr, wdata, byte_en, ren, wen,
                  output rdata, ack, err);
endinterface

// File: rtl/clint_prescaler.sv
// Divides the core clock down to the mtime tick: one tick every PRESCALE clocks.
module clint_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(PRESCALE - 1));
  assign tick   = w_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST)         r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/clint_timer_unit.sv
// CLINT-style machine timer/software interrupt source with a 32-bit bus slave
// port over the msip, mtimecmp and mtime registers.
module clint_timer_unit
  import clint_types_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic             CLK,
  input  logic             RST,
  clint_timer_unit_if.slave bus,
  output logic             timer_int,
  output logic             timer_int_clear,
  output logic             soft_int,
  output logic             soft_int_clear
);

  mtime_t      r_mtime;
  mtime_t      r_mtimecmp;
  logic        r_msip;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_err;
  logic        r_timer_int;
  logic        r_timer_int_clear;
  logic        r_soft_int;
  logic        r_soft_int_clear;

  logic        w_tick;
  reg_sel_e    w_sel;
  logic        w_mapped;
  logic        w_req;
  logic        w_rd;
  logic [31:0] w_rd_val;
  mtime_t      w_mtime_next;
  mtime_t      w_mtimecmp_next;
  logic        w_msip_next;
  logic        w_timer_int_next;

  clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .tick (w_tick)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_sel = REG_NONE;
    if (bus.addr[31:16] == BASE_ADDR[31:16] && bus.addr[1:0] == 2'b00) begin
      case (bus.addr[15:0])
        MSIP_OFF:        w_sel = REG_MSIP;
        MTIMECMP_LO_OFF: w_sel = REG_CMP_LO;
        MTIMECMP_HI_OFF: w_sel = REG_CMP_HI;
        MTIME_LO_OFF:    w_sel = REG_TIME_LO;
        MTIME_HI_OFF:    w_sel = REG_TIME_HI;
        default:         w_sel = REG_NONE;
      endcase
    end
  end

  assign w_mapped = (w_sel != REG_NONE);
  assign w_req    = bus.ren | bus.wen;
  assign w_rd     = bus.ren & ~bus.wen;

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      REG_MSIP:    w_rd_val = {31'b0, r_msip};
      REG_CMP_LO:  w_rd_val = r_mtimecmp[31:0];
      REG_CMP_HI:  w_rd_val = r_mtimecmp[63:32];
      REG_TIME_LO: w_rd_val = r_mtime[31:0];
      REG_TIME_HI: w_rd_val = r_mtime[63:32];
      default:     w_rd_val = '0;
    endcase
  end

  // A written mtime half overrides the tick; the other half keeps the
  // incremented value, whose upper word already carries from the old low word.
  always_comb begin
    w_mtime_next    = r_mtime + mtime_t'(w_tick);
    w_mtimecmp_next = r_mtimecmp;
    w_msip_next     = r_msip;
    if (bus.wen) begin
      case (w_sel)
        REG_MSIP:    if (bus.byte_en[0]) w_msip_next = bus.wdata[0];
        REG_CMP_LO:  w_mtimecmp_next[31:0]  = merge_lanes(r_mtimecmp[31:0],  bus.wdata, bus.byte_en);
        REG_CMP_HI:  w_mtimecmp_next[63:32] = merge_lanes(r_mtimecmp[63:32], bus.wdata, bus.byte_en);
        REG_TIME_LO: w_mtime_next[31:0]     = merge_lanes(r_mtime[31:0],     bus.wdata, bus.byte_en);
        REG_TIME_HI: w_mtime_next[63:32]    = merge_lanes(r_mtime[63:32],    bus.wdata, bus.byte_en);
        default: ;
      endcase
    end
  end

  assign w_timer_int_next = (w_mtime_next >= w_mtimecmp_next);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mtime           <= '0;
      r_mtimecmp        <= '1;
      r_msip            <= 1'b0;
      r_rdata           <= '0;
      r_ack             <= 1'b0;
      r_err             <= 1'b0;
      r_timer_int       <= 1'b0;
      r_timer_int_clear <= 1'b0;
      r_soft_int        <= 1'b0;
      r_soft_int_clear  <= 1'b0;
    end else begin
      r_mtime           <= w_mtime_next;
      r_mtimecmp        <= w_mtimecmp_next;
      r_msip            <= w_msip_next;
      r_rdata           <= (w_rd && w_mapped) ? w_rd_val : 32'h0;
      r_ack             <= w_req;
      r_err             <= w_req & ~w_mapped;
      r_timer_int       <= w_timer_int_next;
      r_timer_int_clear <= r_timer_int & ~w_timer_int_next;
      r_soft_int        <= w_msip_next;
      r_soft_int_clear  <= r_soft_int & ~w_msip_next;
    end
  end

  assign bus.rdata       = r_rdata;
  assign bus.ack         = r_ack;
  assign bus.err         = r_err;
  assign timer_int       = r_timer_int;
  assign timer_int_clear = r_timer_int_clear;
  assign soft_int        = r_soft_int;
  assign soft_int_clear  = r_soft_int_clear;

endmodule
